// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;
  localparam int XLEN_ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;
endpackage

// File: rtl/muldiv_unit.sv
// EX-stage multiply/divide unit owning HI/LO: one result bit per cycle on
// operand magnitudes, with the sign fixup applied in a single FIX cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic            mf_req,
  input  logic            cancel,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            stall
);
  localparam logic [XLEN-1:0]   ONE   = XLEN'(1);
  localparam logic [2*XLEN-1:0] ONE_W = (2*XLEN)'(1);

  function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] x);
    return ~x + ONE_W;
  endfunction

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   ma_q, ma_d, mb_q, mb_d, a_raw_q, a_raw_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  op_e               op_q, op_d;
  logic              bz_q, bz_d, sa_q, sa_d, sx_q, sx_d;

  // Magnitudes of the incoming operands; unsigned ops never negate.
  logic            in_signed, in_sa, in_sb;
  logic [XLEN-1:0] in_ma, in_mb;
  assign in_signed = ~op[0];
  assign in_sa     = in_signed & rs_val[XLEN-1];
  assign in_sb     = in_signed & rt_val[XLEN-1];
  assign in_ma     = in_sa ? (~rs_val + ONE) : rs_val;
  assign in_mb     = in_sb ? (~rt_val + ONE) : rt_val;

  // Multiply: acc = {partial, multiplier}, add multiplicand on LSB then shift.
  logic [XLEN:0]     msum;
  logic [2*XLEN-1:0] mul_nxt;
  assign msum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? ma_q : '0)};
  assign mul_nxt = {msum, acc_q[XLEN-1:1]};

  // Divide: acc = {remainder, dividend/quotient}, restoring subtract.
  logic [XLEN:0]     drem, dsub;
  logic              dge;
  logic [2*XLEN-1:0] div_nxt;
  assign drem    = acc_q[2*XLEN-1:XLEN-1];
  assign dge     = drem >= {1'b0, mb_q};
  assign dsub    = drem - {1'b0, mb_q};
  assign div_nxt = {(dge ? dsub[XLEN-1:0] : drem[XLEN-1:0]), acc_q[XLEN-2:0], dge};

  logic              is_div;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  assign is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign prod   = ((op_q == OP_MULT) && sx_q) ? neg_dw(acc_q) : acc_q;
  assign quo    = ((op_q == OP_DIV) && sx_q) ? (~acc_q[XLEN-1:0] + ONE) : acc_q[XLEN-1:0];
  assign rem    = ((op_q == OP_DIV) && sa_q) ? (~acc_q[2*XLEN-1:XLEN] + ONE)
                                             : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    a_raw_d = a_raw_q;
    op_d    = op_q;
    bz_d    = bz_q;
    sa_d    = sa_q;
    sx_d    = sx_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        // A flush squashes a launching instruction too; start beats mthi/mtlo.
        if (start && !cancel) begin
          state_d = S_RUN;
          cnt_d   = 5'(XLEN_ITER - 1);
          op_d    = op_e'(op);
          ma_d    = in_ma;
          mb_d    = in_mb;
          a_raw_d = rs_val;
          bz_d    = (rt_val == '0);
          sa_d    = in_sa;
          sx_d    = in_sa ^ in_sb;
          acc_d   = op[1] ? {{XLEN{1'b0}}, in_ma} : {{XLEN{1'b0}}, in_mb};
        end else begin
          if (mthi) hi_d = rs_val;
          if (mtlo) lo_d = rs_val;
        end
      end
      S_RUN: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          acc_d = is_div ? div_nxt : mul_nxt;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!cancel) begin
          if (!is_div) begin
            hi_d = prod[2*XLEN-1:XLEN];
            lo_d = prod[XLEN-1:0];
          end else if (bz_q) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      a_raw_q <= '0;
      op_q    <= OP_MULT;
      bz_q    <= 1'b0;
      sa_q    <= 1'b0;
      sx_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      a_raw_q <= a_raw_d;
      op_q    <= op_d;
      bz_q    <= bz_d;
      sa_q    <= sa_d;
      sx_q    <= sx_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign stall = busy & (start | mf_req | mthi | mtlo);
  assign hi    = hi_q;
  assign lo    = lo_q;
endmodule
